uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 30 +++
 rtl/uart_rx.sv | 167 ++++++++++++++++
 tb/tb_uart_rx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry constants
// common to the tx/rx pair, and the 2-of-3 vote used for noisy-line sampling.
// No logic, no latency, no flow control.
package uart_pkg;

  // Frame geometry shared with the transmitter.
  localparam int UART_CLKS_PER_BIT = 16;
  localparam int UART_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  // 2-of-3 majority vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, reset to RST_VAL.
// Latency: 2 clk cycles from d_i to q_o.
// No flow control; samples every cycle.
// Ports: clk, rst (sync active-high), d_i (async input), q_o (synchronised).
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, DATA_BITS data (MSB first), 1 stop, CLKS_PER_BIT clocks/bit.
// Latency: valid rises after edge 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT from the start edge.
// No backpressure: valid/frame_err are single-cycle strobes the consumer must take.
// Ports: clk, rst (sync active-high), din (raw async line, idles high),
//        dout (last good byte), valid (dout updated), frame_err (stop bit low),
//        busy (receiver not idle).
// Option: define UART_RX_MAJORITY_EN to take every bit decision as the 2-of-3
//         vote of the synchronised line at counts D-2, D-1, D.
// CLKS_PER_BIT must be even and >= 8 so the vote window fits inside each count run.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  output logic [DATA_BITS-1:0] dout,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic s;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (din),
    .q_o (s)
  );

  rx_state_t            state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic [DATA_BITS-1:0] sr_q;
  logic [DATA_BITS-1:0] dout_q;
  logic                 valid_q;
  logic                 frame_err_q;
  logic                 busy_q;
  logic                 samp;

`ifdef UART_RX_MAJORITY_EN
  // Free-running history of s. The counter advances every cycle inside
  // START/DATA/STOP, so the two previous cycles are exactly counts D-1, D-2
  // whenever a decision is taken at count D.
  logic [1:0] hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], s};
    end
  end

  assign samp = maj3(hist_q[1], hist_q[0], s);
`else
  assign samp = s;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      sr_q        <= '0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (!s) begin
            cnt_q   <= '0;
            state_q <= START;
            busy_q  <= 1'b1;
          end
        end

        START: begin
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_HALF) begin
            if (!samp) begin
              // Start bit confirmed at its centre; from here every
              // CLKS_PER_BIT cycles lands on a data-bit centre.
              cnt_q     <= '0;
              bit_idx_q <= '0;
              state_q   <= DATA;
            end else begin
              // Line came back high: treat as a glitch.
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end

        DATA: begin
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            cnt_q     <= '0;
            sr_q      <= {sr_q[DATA_BITS-2:0], samp};
            bit_idx_q <= bit_idx_q + IDX_ONE;
            if (bit_idx_q == IDX_LAST) begin
              state_q <= STOP;
            end
          end
        end

        STOP: begin
          cnt_q <= cnt_q + CNT_ONE;
          // Leaving at the stop-bit centre leaves half a bit of margin to
          // catch the next start edge of a back-to-back frame.
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (samp) begin
              dout_q  <= sr_q;
              valid_q <= 1'b1;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= BREAK;
            end
          end
        end

        BREAK: begin
          // Line held low after a bad stop bit: wait for it to release so
          // the low level is not mistaken for a new start bit.
          if (s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dout      = dout_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames from a bit-level tx model,
// a table of frames with expected strobe counts and dout, and hand-written
// sequences for timing, back-to-back, glitch, break, mid-frame reset, voting.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       rst;
  logic       din;
  logic [7:0] dout;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .dout      (dout),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising-edge counter; at a negedge it equals the number of the edge just taken.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Strobe monitor, sampled on the falling edge.
  int         vcnt = 0;
  int         fcnt = 0;
  int         both = 0;
  int         vcyc = -1;
  int         fcyc = -1;
  int         brise = -1;
  int         bfall = -1;
  logic       busy_prev = 1'b0;
  logic [7:0] vq[$];

  always @(negedge clk) begin
    if (valid) begin
      vcnt = vcnt + 1;
      vcyc = cyc;
      vq.push_back(dout);
    end
    if (frame_err) begin
      fcnt = fcnt + 1;
      fcyc = cyc;
    end
    if (valid && frame_err) both = both + 1;
    if (busy && !busy_prev) brise = cyc;
    if (!busy && busy_prev) bfall = cyc;
    busy_prev = busy;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; holds the level for one bit period.
  task automatic put_bit(input logic b);
    din = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Bit-level model of the transmitter. e0 is the first edge that sees the start bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, output int e0);
    e0 = cyc + 1;
    put_bit(1'b0);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    put_bit(stop_b);
    din = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_v;
    int         exp_f;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int         e0;
    int         e1;
    int         v0;
    int         f0;
    int         q0;
    logic [7:0] dd;
    logic [7:0] exp_maj;

    vecs[0] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[1] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[2] = '{8'hC3, 1'b0, 0, 1, 8'hFF};
    vecs[3] = '{8'h81, 1'b1, 1, 0, 8'h81};
    vecs[4] = '{8'h6E, 1'b1, 1, 0, 8'h6E};

    rst = 1'b1;
    din = 1'b1;
    idle(3);
    chk("reset_dout", int'(dout), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    chk("reset_busy", int'(busy), 0);
    rst = 1'b0;
    idle(5);

    // 0xA5 with exact strobe and busy timing.
    v0 = vcnt; f0 = fcnt;
    send_frame(8'hA5, 1'b1, e0);
    idle(20);
    chk("a5_valid_count", vcnt - v0, 1);
    chk("a5_valid_edge", vcyc - e0, 154);
    chk("a5_dout", int'(dout), 8'hA5);
    chk("a5_no_frame_err", fcnt - f0, 0);
    chk("a5_busy_rise_edge", brise - e0, 2);
    chk("a5_busy_fall_edge", bfall - e0, 154);

    // Table of single frames separated by idle gaps.
    for (int n = 0; n < 5; n++) begin
      v0 = vcnt; f0 = fcnt;
      send_frame(vecs[n].data, vecs[n].stop, e0);
      idle(20);
      chk($sformatf("vec%0d_valid_count", n), vcnt - v0, vecs[n].exp_v);
      chk($sformatf("vec%0d_ferr_count", n), fcnt - f0, vecs[n].exp_f);
      chk($sformatf("vec%0d_dout", n), int'(dout), int'(vecs[n].exp_dout));
    end

    // Back-to-back 0x00 then 0xFF with no idle gap.
    v0 = vcnt; f0 = fcnt; q0 = vq.size();
    send_frame(8'h00, 1'b1, e0);
    send_frame(8'hFF, 1'b1, e1);
    idle(20);
    chk("b2b_valid_count", vcnt - v0, 2);
    chk("b2b_ferr_count", fcnt - f0, 0);
    chk("b2b_first", (vq.size() > q0) ? int'(vq[q0]) : -1, 8'h00);
    chk("b2b_second", (vq.size() > q0 + 1) ? int'(vq[q0 + 1]) : -1, 8'hFF);

    // Short low pulse: rejected at the start-bit centre.
    v0 = vcnt; f0 = fcnt; q0 = brise;
    din = 1'b0;
    idle(4);
    din = 1'b1;
    idle(7);
    chk("glitch_busy_seen", int'(brise != q0), 1);
    chk("glitch_busy_dropped", int'(busy), 0);
    idle(20);
    chk("glitch_no_valid", vcnt - v0, 0);
    chk("glitch_no_ferr", fcnt - f0, 0);

    // Bad stop bit with the line then held low (break).
    v0 = vcnt; f0 = fcnt;
    send_frame(8'h3C, 1'b0, e0);
    din = 1'b0;
    idle(40);
    chk("brk_ferr_count", fcnt - f0, 1);
    chk("brk_ferr_edge", fcyc - e0, 154);
    chk("brk_no_valid", vcnt - v0, 0);
    chk("brk_dout_kept", int'(dout), 8'hFF);
    chk("brk_busy_held", int'(busy), 1);
    din = 1'b1;
    idle(6);
    chk("brk_busy_released", int'(busy), 0);
    v0 = vcnt;
    send_frame(8'h81, 1'b1, e0);
    idle(20);
    chk("after_brk_valid", vcnt - v0, 1);
    chk("after_brk_dout", int'(dout), 8'h81);

    // Reset during data bit 3 of 0x5A; the transmitter is reset too.
    v0 = vcnt; f0 = fcnt;
    dd = 8'h5A;
    put_bit(1'b0);
    for (int i = 7; i >= 5; i--) put_bit(dd[i]);
    din = dd[4];
    idle(8);
    chk("mid_busy_before_rst", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_dout", int'(dout), 0);
    chk("mid_rst_valid", int'(valid), 0);
    chk("mid_rst_ferr", int'(frame_err), 0);
    chk("mid_rst_busy", int'(busy), 0);
    rst = 1'b0;
    din = 1'b1;
    idle(200);
    chk("mid_no_valid", vcnt - v0, 0);
    chk("mid_no_ferr", fcnt - f0, 0);
    send_frame(8'h12, 1'b1, e0);
    idle(20);
    chk("post_rst_valid", vcnt - v0, 1);
    chk("post_rst_dout", int'(dout), 8'h12);

    // 0xF0 with a one-cycle inverted glitch landing on each data decision.
    v0 = vcnt;
    dd = 8'hF0;
    put_bit(1'b0);
    for (int i = 7; i >= 0; i--) begin
      din = dd[i];
      idle(8);
      din = ~dd[i];
      idle(1);
      din = dd[i];
      idle(7);
    end
    put_bit(1'b1);
    idle(20);
`ifdef UART_RX_MAJORITY_EN
    exp_maj = 8'hF0;
`else
    exp_maj = 8'h0F;
`endif
    chk("vote_valid", vcnt - v0, 1);
    chk("vote_dout", int'(dout), int'(exp_maj));

    chk("valid_ferr_exclusive", both, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
